// File: rtl/tp_rom_pkg.sv
// tp_rom_pkg: region map, region and state enums, and decode helpers
// shared by the ROM loader and its checksum accumulator.
package tp_rom_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERR
    } state_e;

    typedef enum logic [2:0] {
        RG_CPU,
        RG_SND,
        RG_TILE,
        RG_SPR,
        RG_PROM,
        RG_NONE
    } region_e;

    localparam logic [24:0] CPU_BASE  = 25'h00000;
    localparam logic [24:0] CPU_SIZE  = 25'h06000;
    localparam logic [24:0] SND_BASE  = 25'h06000;
    localparam logic [24:0] SND_SIZE  = 25'h01000;
    localparam logic [24:0] TILE_BASE = 25'h07000;
    localparam logic [24:0] TILE_SIZE = 25'h02000;
    localparam logic [24:0] SPR_BASE  = 25'h09000;
    localparam logic [24:0] SPR_SIZE  = 25'h04000;
    localparam logic [24:0] PROM_BASE = 25'h0D000;
    localparam logic [24:0] PROM_SIZE = 25'h00240;

    function automatic region_e region_of(input logic [24:0] a);
        if (a < CPU_BASE + CPU_SIZE) begin
            return RG_CPU;
        end else if (a < SND_BASE + SND_SIZE) begin
            return RG_SND;
        end else if (a < TILE_BASE + TILE_SIZE) begin
            return RG_TILE;
        end else if (a < SPR_BASE + SPR_SIZE) begin
            return RG_SPR;
        end else if (a < PROM_BASE + PROM_SIZE) begin
            return RG_PROM;
        end
        return RG_NONE;
    endfunction

    function automatic logic [24:0] region_base(input region_e r);
        unique case (r)
            RG_CPU:  return CPU_BASE;
            RG_SND:  return SND_BASE;
            RG_TILE: return TILE_BASE;
            RG_SPR:  return SPR_BASE;
            RG_PROM: return PROM_BASE;
            default: return 25'h0;
        endcase
    endfunction

    function automatic logic [4:0] region_we(input region_e r);
        unique case (r)
            RG_CPU:  return 5'b00001;
            RG_SND:  return 5'b00010;
            RG_TILE: return 5'b00100;
            RG_SPR:  return 5'b01000;
            RG_PROM: return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/tp_rom_sum.sv
// tp_rom_sum: 16-bit wrapping sum of accepted image bytes; also exposes
// the next-cycle sum so a same-cycle final byte joins the pass check.
module tp_rom_sum (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        add_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] sum_o,
    output logic [15:0] sum_d_o
);

    logic [15:0] sum_q;
    logic [15:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = 16'h0000;
        end else if (add_i) begin
            sum_d = sum_q + {8'h00, byte_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q <= 16'h0000;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o   = sum_q;
    assign sum_d_o = sum_d;

endmodule

// File: rtl/tp_rom_loader.sv
// tp_rom_loader: turns HPS ioctl bytes into per-region ROM write strobes.
// Define ROM_CHECKSUM_EN to add the image checksum and the rom_sum port.
module tp_rom_loader #(
    parameter int          TOTAL_BYTES    = 53824,
    parameter logic [15:0] ROM_SUM_EXPECT = 16'h0000
) (
    input  logic        clk_49m,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [4:0]  rom_we,
    output logic        rom_ready,
    output logic        load_err,
    output logic [15:0] byte_count
`ifdef ROM_CHECKSUM_EN
   ,output logic [15:0] rom_sum
`endif
);

    import tp_rom_pkg::*;

    localparam logic [24:0] TOTAL_A = 25'(TOTAL_BYTES);
    localparam logic [15:0] TOTAL_C = 16'(TOTAL_BYTES);

    state_e      state_q, state_d;
    logic        dl_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [4:0]  we_q, we_d;
    logic        ovr_q, ovr_d;

    logic        dl_rise, dl_fall;
    logic        idx0, in_rng, wr_ok;
    logic        sum_clr, sum_add, sum_ok;
    region_e     rg;

    always_comb begin
        dl_rise = ioctl_download & ~dl_q;
        dl_fall = ~ioctl_download & dl_q;
        idx0    = (ioctl_index == 8'd0);
        in_rng  = (ioctl_addr < TOTAL_A);
        wr_ok   = ioctl_wr & idx0;
        rg      = region_of(ioctl_addr);
        sum_add = (state_q == LOAD) & wr_ok & in_rng;
        sum_clr = (state_q != LOAD) & dl_rise & idx0;
    end

`ifdef ROM_CHECKSUM_EN
    logic [15:0] sum_nxt;

    tp_rom_sum u_sum (
        .clk_i   (clk_49m),
        .rst_i   (reset),
        .clr_i   (sum_clr),
        .add_i   (sum_add),
        .byte_i  (ioctl_dout),
        .sum_o   (rom_sum),
        .sum_d_o (sum_nxt)
    );

    // An expected sum of zero means "don't care".
    assign sum_ok = (ROM_SUM_EXPECT == 16'h0000) || (sum_nxt == ROM_SUM_EXPECT);
`else
    logic unused_cfg;

    assign unused_cfg = ^{ROM_SUM_EXPECT, sum_clr};
    assign sum_ok     = 1'b1;
`endif

    // Completion uses the _d values so a write on the falling edge counts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        we_d    = 5'b00000;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            LOAD: begin
                if (sum_add) begin
                    we_d   = region_we(rg);
                    addr_d = 16'(ioctl_addr - region_base(rg));
                    data_d = ioctl_dout;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                if (wr_ok && !in_rng) begin
                    ovr_d = 1'b1;
                end
                if (dl_fall) begin
                    if (cnt_d == TOTAL_C && !ovr_d && sum_ok) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            default: begin
                if (sum_clr) begin
                    state_d = LOAD;
                    cnt_d   = 16'h0000;
                    ovr_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_49m or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dl_q    <= 1'b0;
            cnt_q   <= 16'h0000;
            ovr_q   <= 1'b0;
            we_q    <= 5'b00000;
            addr_q  <= 16'h0000;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            dl_q    <= ioctl_download;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign rom_we     = we_q;
    assign rom_addr   = addr_q;
    assign rom_data   = data_q;
    assign byte_count = cnt_q;
    assign rom_ready  = (state_q == DONE);
    assign load_err   = (state_q == ERR);

endmodule

// File: tb/tb_tp_rom_loader.sv
// tb_tp_rom_loader: full-size and 64-byte loaders driven together and
// checked every cycle against a download-level model of the loader.
module tb_tp_rom_loader;

    localparam int NI  = 2;
    localparam int BIG = 53824;
    localparam int SML = 64;
`ifdef ROM_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;

    logic [15:0] a_addr [NI];
    logic [7:0]  a_data [NI];
    logic [4:0]  a_we   [NI];
    logic        a_rdy  [NI];
    logic        a_err  [NI];
    logic [15:0] a_cnt  [NI];
`ifdef ROM_CHECKSUM_EN
    logic [15:0] a_sum  [NI];
`endif

    always #5 clk = ~clk;

    tp_rom_loader #(.TOTAL_BYTES(BIG), .ROM_SUM_EXPECT(16'h0000)) dut (
        .clk_49m(clk), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .rom_addr(a_addr[0]), .rom_data(a_data[0]),
        .rom_we(a_we[0]), .rom_ready(a_rdy[0]), .load_err(a_err[0]),
        .byte_count(a_cnt[0])
`ifdef ROM_CHECKSUM_EN
       ,.rom_sum(a_sum[0])
`endif
    );

    tp_rom_loader #(.TOTAL_BYTES(SML), .ROM_SUM_EXPECT(16'h1234)) dut_s (
        .clk_49m(clk), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .rom_addr(a_addr[1]), .rom_data(a_data[1]),
        .rom_we(a_we[1]), .rom_ready(a_rdy[1]), .load_err(a_err[1]),
        .byte_count(a_cnt[1])
`ifdef ROM_CHECKSUM_EN
       ,.rom_sum(a_sum[1])
`endif
    );

    int          tot  [NI] = '{BIG, SML};
    logic [15:0] sexp [NI] = '{16'h0000, 16'h1234};

    bit          m_load [NI];
    bit          m_rdy  [NI];
    bit          m_err  [NI];
    bit          m_ovr  [NI];
    int          m_cnt  [NI];
    logic [15:0] m_sum  [NI];
    logic [4:0]  e_we   [NI];
    logic [15:0] e_addr [NI];
    logic [7:0]  e_data [NI];
    bit          prev_dl;

    logic [7:0]  img [BIG];
    int          pc [5];
    bit          tally = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void region(input int a, output logic [4:0] w, output int base);
        if (a < 'h6000) begin
            w = 5'b00001; base = 'h0;
        end else if (a < 'h7000) begin
            w = 5'b00010; base = 'h6000;
        end else if (a < 'h9000) begin
            w = 5'b00100; base = 'h7000;
        end else if (a < 'hD000) begin
            w = 5'b01000; base = 'h9000;
        end else if (a < 'hD240) begin
            w = 5'b10000; base = 'hD000;
        end else begin
            w = 5'b00000; base = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NI; k++) begin
            m_load[k] = 0; m_rdy[k] = 0; m_err[k] = 0; m_ovr[k] = 0;
            m_cnt[k] = 0; m_sum[k] = 16'h0;
            e_we[k] = 5'h0; e_addr[k] = 16'h0; e_data[k] = 8'h0;
        end
        prev_dl = 0;
    endfunction

    // Called once per clock with the inputs the DUT just sampled.
    function automatic void model_step();
        bit rise, fall, ok;
        logic [4:0] w;
        int base, a;
        rise = ioctl_download && !prev_dl;
        fall = !ioctl_download && prev_dl;
        a = int'(ioctl_addr);
        for (int k = 0; k < NI; k++) begin
            e_we[k] = 5'h0;
            if (!m_load[k]) begin
                if (rise && ioctl_index == 8'd0) begin
                    m_load[k] = 1; m_rdy[k] = 0; m_err[k] = 0;
                    m_cnt[k] = 0; m_ovr[k] = 0; m_sum[k] = 16'h0;
                end
            end else begin
                if (ioctl_wr && ioctl_index == 8'd0) begin
                    if (a < tot[k]) begin
                        region(a, w, base);
                        e_we[k] = w;
                        e_addr[k] = 16'(a - base);
                        e_data[k] = ioctl_dout;
                        if (m_cnt[k] < 65535) m_cnt[k]++;
                        m_sum[k] = m_sum[k] + {8'h00, ioctl_dout};
                    end else begin
                        m_ovr[k] = 1;
                    end
                end
                if (fall) begin
                    ok = (m_cnt[k] == tot[k]) && !m_ovr[k] &&
                         (!CSUM || sexp[k] == 16'h0 || m_sum[k] == sexp[k]);
                    m_load[k] = 0; m_rdy[k] = ok; m_err[k] = !ok;
                end
            end
        end
        prev_dl = ioctl_download;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rom_we[%0d]", k), 32'(a_we[k]), 32'(e_we[k]));
            chk($sformatf("rom_ready[%0d]", k), 32'(a_rdy[k]), 32'(m_rdy[k]));
            chk($sformatf("load_err[%0d]", k), 32'(a_err[k]), 32'(m_err[k]));
            chk($sformatf("byte_count[%0d]", k), 32'(a_cnt[k]), 32'(m_cnt[k]));
            if (e_we[k] != 5'h0 || reset) begin
                chk($sformatf("rom_addr[%0d]", k), 32'(a_addr[k]), 32'(e_addr[k]));
                chk($sformatf("rom_data[%0d]", k), 32'(a_data[k]), 32'(e_data[k]));
            end
`ifdef ROM_CHECKSUM_EN
            chk($sformatf("rom_sum[%0d]", k), 32'(a_sum[k]), 32'(m_sum[k]));
`endif
        end
        if (tally)
            for (int b = 0; b < 5; b++)
                if (a_we[0][b]) pc[b]++;
    end

    task automatic step(input bit dl, input logic [7:0] idx, input bit wr,
                        input int addr, input logic [7:0] d);
        ioctl_download = dl;
        ioctl_index    = idx;
        ioctl_wr       = wr;
        ioctl_addr     = 25'(addr);
        ioctl_dout     = d;
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Sequential image load; the last write coincides with the falling edge.
    task automatic load_img(input int n, input int extra, input bit gaps);
        step(1'b1, 8'd0, 1'b0, 0, 8'h00);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(7) == 0)
                step(1'b1, ($urandom_range(1) != 0) ? 8'd254 : 8'd3,
                     1'($urandom_range(1)), int'($urandom_range(0, 'hD23F)), 8'($urandom));
            step((extra < 0 && i == n - 1) ? 1'b0 : 1'b1, 8'd0, 1'b1, i, img[i]);
        end
        if (extra >= 0) step(1'b0, 8'd0, 1'b1, extra, 8'h77);
        step(1'b0, 8'd0, 1'b1, 5, 8'hAA);
        step(1'b0, 8'd0, 1'b0, 0, 8'h00);
    endtask

    initial begin
        int r;
        for (int i = 0; i < SML; i++) img[i] = 8'd72;
        img[SML-1] = 8'd124;
        for (int i = 0; i < SML / 2; i++) begin
            r = int'($urandom_range(0, 50));
            img[2*i]   = img[2*i] + 8'(r);
            img[2*i+1] = img[2*i+1] - 8'(r);
        end
        for (int i = SML; i < BIG; i++) img[i] = 8'($urandom);
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_count", 32'(a_cnt[0]), 32'd0);
        chk("reset_ready", 32'(a_rdy[0]), 32'd0);
        reset = 1'b0;

        load_img(SML - 1, -1, 1'b0);
        chk("short_err", 32'(a_err[1]), 32'd1);
        chk("short_ready", 32'(a_rdy[1]), 32'd0);

        img[SML-1] = img[SML-1] + 8'd1;
        load_img(SML, -1, 1'b0);
`ifdef ROM_CHECKSUM_EN
        chk("badsum_err", 32'(a_err[1]), 32'd1);
`endif
        img[SML-1] = img[SML-1] - 8'd1;

        load_img(SML, -1, 1'b1);
        chk("reload_ready", 32'(a_rdy[1]), 32'd1);
        chk("reload_count", 32'(a_cnt[1]), 32'd64);
`ifdef ROM_CHECKSUM_EN
        chk("good_sum", 32'(a_sum[1]), 32'h1234);
`endif

        load_img(SML, SML, 1'b0);
        chk("overrun_err", 32'(a_err[1]), 32'd1);
        chk("overrun_count", 32'(a_cnt[1]), 32'd64);

        step(1'b1, 8'd0, 1'b0, 0, 8'h00);
        step(1'b1, 8'd0, 1'b1, 'h7001, 8'h5A);
        chk("tile_we", 32'(a_we[0]), 32'b00100);
        chk("tile_addr", 32'(a_addr[0]), 32'h0001);
        chk("tile_data", 32'(a_data[0]), 32'h5A);
        for (int i = 0; i < 999; i++) step(1'b1, 8'd0, 1'b1, i, img[i]);
        chk("count_1000", 32'(a_cnt[0]), 32'd1000);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_we", 32'(a_we[0]), 32'd0);
        chk("async_count", 32'(a_cnt[0]), 32'd0);
        chk("async_addr", 32'(a_addr[0]), 32'd0);
        chk("async_data", 32'(a_data[0]), 32'd0);
        ioctl_download = 1'b0;
        ioctl_index = 8'd254;
        ioctl_wr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 8'd254, 1'b0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 8'd254, 1'b1, 'h10 + i, 8'h3C);
        chk("dip_count", 32'(a_cnt[0]), 32'd0);
        chk("dip_we", 32'(a_we[0]), 32'd0);
        step(1'b0, 8'd254, 1'b0, 0, 8'h00);

        ioctl_download = 1'b1;
        ioctl_index = 8'd0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 8'd0, 1'b1, 0, img[0]);
        step(1'b1, 8'd0, 1'b1, 1, img[1]);
        chk("held_dl_count", 32'(a_cnt[0]), 32'd1);
        step(1'b0, 8'd0, 1'b0, 0, 8'h00);
        chk("held_dl_err", 32'(a_err[0]), 32'd1);

        for (int b = 0; b < 5; b++) pc[b] = 0;
        tally = 1'b1;
        load_img(BIG, -1, 1'b1);
        tally = 1'b0;
        chk("pulses_cpu", 32'(pc[0]), 32'd24576);
        chk("pulses_snd", 32'(pc[1]), 32'd4096);
        chk("pulses_tile", 32'(pc[2]), 32'd8192);
        chk("pulses_spr", 32'(pc[3]), 32'd16384);
        chk("pulses_prom", 32'(pc[4]), 32'd576);
        chk("full_ready", 32'(a_rdy[0]), 32'd1);
        chk("full_err", 32'(a_err[0]), 32'd0);
        chk("full_count", 32'(a_cnt[0]), 32'hD240);

        load_img(10, 'hD240, 1'b0);
        chk("big_overrun_err", 32'(a_err[0]), 32'd1);
        chk("big_overrun_ready", 32'(a_rdy[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        miscompares++;
        $display("FAIL timeout: bench did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tp_rom_loader.md
TP_ROM_LOADER -- requirements
Module: tp_rom_loader

Interface
REQ-001 Parameter TOTAL_BYTES, default 53824 (0xD240); expected ROM image length in bytes.
REQ-002 Parameter ROM_SUM_EXPECT, default 0; expected 16-bit image sum; 0 disables the comparison.
REQ-003 clk_49m  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ioctl_download  in  1  HPS download in progress.
REQ-006 ioctl_index  in  8  download slot; only index 0 is ROM data.
REQ-007 ioctl_wr  in  1  one-cycle byte-write strobe.
REQ-008 ioctl_addr  in  25  byte address in the image.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 rom_addr  out  16  offset within the selected region.
REQ-011 rom_data  out  8  byte to write.
REQ-012 rom_we  out  5  one-hot strobe: [0] CPU, [1] sound, [2] tiles, [3] sprites, [4] PROMs.
REQ-013 rom_ready  out  1  image complete and valid; core may leave reset.
REQ-014 load_err  out  1  sticky error for the last download.
REQ-015 byte_count  out  16  in-range bytes accepted during the current or last load.

Function
REQ-016 Region map: CPU 0x00000-0x05FFF, sound 0x06000-0x06FFF, tiles 0x07000-0x08FFF, sprites 0x09000-0x0CFFF, PROMs 0x0D000-0x0D23F.
REQ-017 rom_addr SHALL equal ioctl_addr minus the base of the decoded region.
REQ-018 States SHALL be IDLE, LOAD, DONE and ERR.
REQ-019 IDLE/DONE/ERR -> LOAD on a rising edge of ioctl_download when ioctl_index==0; on entry, byte_count, checksum and load_err are cleared and rom_ready is driven low.
REQ-020 In LOAD, for each ioctl_wr with index 0 and ioctl_addr < TOTAL_BYTES, exactly one rom_we bit SHALL pulse for one cycle, one clock after the strobe, with rom_addr and rom_data registered alongside it; byte_count is incremented by one.
REQ-021 A write with ioctl_addr >= TOTAL_BYTES SHALL produce no rom_we pulse and SHALL set an overrun flag.
REQ-022 A write with ioctl_index != 0 SHALL be ignored in every state.
REQ-023 Writes arriving in IDLE, DONE or ERR SHALL be ignored.
REQ-024 On a falling edge of ioctl_download in LOAD, the block goes to DONE when byte_count==TOTAL_BYTES, there was no overrun and the checksum passes; otherwise it goes to ERR.
REQ-025 rom_ready SHALL be 1 only in DONE; load_err SHALL be 1 only in ERR.
REQ-026 byte_count SHALL saturate at 0xFFFF and never wrap.
REQ-027 If a write strobe and the falling edge of ioctl_download occur in the same cycle, the write is counted before the completion check.
REQ-028 Duplicate addresses SHALL be written and counted again; a short load therefore still reports ERR, because the count is checked, not coverage.

Reset
REQ-029 Asserting reset in any state, including mid-LOAD, SHALL force IDLE on the next evaluation, asynchronously.
REQ-030 While reset is asserted, all outputs SHALL be 0: rom_we=0, rom_ready=0, load_err=0, byte_count=0, rom_addr=0, rom_data=0.
REQ-031 Edge detectors SHALL reset to 0, so a download already high at reset release counts as a rising edge.

Configuration
REQ-032 With ROM_CHECKSUM_EN defined: each accepted byte is added to a 16-bit wrapping sum, and output rom_sum[15:0] exists.
REQ-033 With ROM_CHECKSUM_EN defined and ROM_SUM_EXPECT != 0: the REQ-024 pass condition includes rom_sum == ROM_SUM_EXPECT.
REQ-034 Without ROM_CHECKSUM_EN: there is no rom_sum port and no accumulator, and the checksum condition is always true.

Structure
REQ-035 Shared package tp_rom_pkg SHALL hold the region base/size constants, the region index enum and the state enum (IDLE, LOAD, DONE, ERR).
REQ-036 The accumulator SHALL be a single sub-module, tp_rom_sum, instantiated only under ROM_CHECKSUM_EN.

Verification
REQ-037 Full sequential load of 53824 bytes at index 0, then download falls -> rom_we[0] pulses 24576 times, [1] 4096, [2] 8192, [3] 16384, [4] 576; rom_ready=1, load_err=0, byte_count=0xD240.
REQ-038 Write at ioctl_addr=0x07001 with data 0x5A -> one cycle later rom_we=5'b00100, rom_addr=0x0001, rom_data=0x5A.
REQ-039 Load stops after 0xD23F bytes -> ERR, load_err=1, rom_ready=0; a later full reload -> DONE.
REQ-040 Extra write at ioctl_addr=0x0D240 -> no rom_we pulse; state ERR at the end of the download.
REQ-041 reset pulsed after 1000 bytes -> all outputs 0 and state IDLE; an index-254 DIP write afterwards -> no rom_we pulse, byte_count stays 0.
REQ-042 With ROM_CHECKSUM_EN, ROM_SUM_EXPECT=0x1234 and an image summing to 0x1235 -> ERR; the corrected image -> DONE with rom_sum=0x1234.
